// File: rtl/prbs_pkg.sv
// Shared PRBS types and the Galois LFSR step used by both generator and checker.
// Pure definitions; no latency or flow control.
package prbs_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } prbs_state_t;

    localparam int MAX_LEN = 32;

    // Right-shifting Galois step on the low 'len' bits; upper bits are masked off.
    function automatic logic [MAX_LEN-1:0] lfsr_step(
        input logic [MAX_LEN-1:0] s,
        input logic [MAX_LEN-1:0] taps,
        input int                 len
    );
        logic [MAX_LEN-1:0] mask;
        mask = (len >= MAX_LEN) ? '1 : ((MAX_LEN'(1) << len) - MAX_LEN'(1));
        return ((s & mask) >> 1) ^ (s[0] ? (taps & mask) : '0);
    endfunction

endpackage

// File: rtl/prbs_sat_cnt.sv
// Saturating event counter with synchronous clear; updates on the edge after inc.
// No backpressure: holds at all-ones instead of wrapping.
module prbs_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: self-seeds from received LFSR words, tracks lock, flags mismatches; latency 1.
// No backpressure (one word per vld cycle); statistics counters built only with PRBS_CHK_STATS_EN.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int             LEN       = 8,
    parameter logic [LEN-1:0] TAPS      = 8'b10111000,
    parameter int             LOCK_ACQ  = 2,
    parameter int             LOCK_LOSS = 4,
    parameter int             CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             vld,
    input  logic [LEN-1:0]   data,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int RUN_MAX = (LOCK_ACQ > LOCK_LOSS) ? LOCK_ACQ : LOCK_LOSS;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    function automatic logic [LEN-1:0] step(input logic [LEN-1:0] s);
        return LEN'(lfsr_step(MAX_LEN'(s), MAX_LEN'(TAPS), LEN));
    endfunction

    prbs_state_t      state;
    logic [LEN-1:0]   pred;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_nxt;
    logic [LEN-1:0]   step_data;
    logic [LEN-1:0]   step_pred;
    logic             match;

    assign run_nxt   = run + RUN_W'(1);
    assign step_data = step(data);
    assign step_pred = step(pred);
    assign match     = (data == pred);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= SEARCH;
            pred   <= '0;
            run    <= '0;
            locked <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= 1'b0;
            if (clr) begin
                state  <= SEARCH;
                run    <= '0;
                locked <= 1'b0;
            end else if (vld) begin
                case (state)
                    SEARCH: begin
                        // All-zero is the LFSR lockup state and can never seed a valid stream.
                        if (data != '0) begin
                            pred  <= step_data;
                            run   <= '0;
                            state <= ACQUIRE;
                        end
                    end
                    ACQUIRE: begin
                        if (match) begin
                            pred <= step_data;
                            if (run_nxt == RUN_W'(LOCK_ACQ)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                run    <= '0;
                            end else begin
                                run <= run_nxt;
                            end
                        end else if (data == '0) begin
                            state <= SEARCH;
                            run   <= '0;
                        end else begin
                            pred <= step_data;
                            run  <= '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            pred <= step_data;
                            run  <= '0;
                        end else begin
                            // Free-run the prediction so a single corrupted word costs one error.
                            err  <= 1'b1;
                            pred <= step_pred;
                            if (run_nxt == RUN_W'(LOCK_LOSS)) begin
                                state  <= SEARCH;
                                locked <= 1'b0;
                                run    <= '0;
                            end else begin
                                run <= run_nxt;
                            end
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        run    <= '0;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PRBS_CHK_STATS_EN
    logic inc_word;
    logic inc_err;

    assign inc_word = vld && !clr && (state == LOCKED);
    assign inc_err  = inc_word && !match;

    prbs_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (inc_err),
        .cnt   (err_cnt)
    );

    prbs_sat_cnt #(.CNT_W(CNT_W)) u_word_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (inc_word),
        .cnt   (word_cnt)
    );
`else
    assign err_cnt  = '0;
    assign word_cnt = '0;
`endif

endmodule
